// File: rtl/norm_pipe.sv
// Post-add normaliser: carry right-shift, leading-zero left-shift, zero/overflow/denormal flags.
// Latency 2 cycles (S1 registers inputs + LZC, S2 registers shifted/adjusted result); 1 beat/cycle.
// Backpressure: combinational ready chain, no skid buffer; outputs held while out_valid & !out_ready.
module norm_pipe #(
  parameter int MW = 24,
  parameter int EW = 8,
  parameter int SW = $clog2(MW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_carry,
  input  logic [MW-1:0] in_mant,
  input  logic [EW-1:0] in_exp,
  input  logic          in_sticky,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] out_mant,
  output logic [EW-1:0] out_exp,
  output logic [SW-1:0] out_shift,
  output logic          out_rshift,
  output logic          out_sticky,
  output logic          out_zero,
  output logic          out_ovf,
  output logic          out_unf
);

  // Exponent arithmetic width: one bit above the exponent so increments and
  // comparisons against the shift count never wrap.
  localparam int XW = ((EW + 1) > (SW + 1)) ? (EW + 1) : (SW + 1);

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_v_q, s1_v_d;
  logic s2_v_q, s2_v_d;
  logic s2_ready;
  logic in_fire;
  logic s2_fire;

  assign s2_ready = !s2_v_q || out_ready;
  assign in_ready = !s1_v_q || s2_ready;
  assign in_fire  = in_valid && in_ready;
  assign s2_fire  = s1_v_q && s2_ready;

  // Stage valids: a stage fills on its load strobe and drains when its beat moves on.
  always_comb begin
    s1_v_d = in_fire || (s1_v_q && !s2_fire);
    s2_v_d = s2_fire || (s2_v_q && !out_ready);
  end

  // Stage valid registers, flushed asynchronously so in-flight beats are lost on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: leading-zero count and input capture
  // ---------------------------------------------------------------------------
  logic [SW-1:0] lzc_d;

  // Priority scan from LSB upward; the highest set bit wins. All-zero gives MW.
  always_comb begin
    lzc_d = SW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (in_mant[i]) lzc_d = SW'(MW - 1 - i);
    end
  end

  logic          s1_carry_q;
  logic [MW-1:0] s1_mant_q;
  logic [EW-1:0] s1_exp_q;
  logic          s1_sticky_q;
  logic [SW-1:0] s1_lzc_q;

  // Stage 1 data registers load only on an accepted input beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_carry_q  <= 1'b0;
      s1_mant_q   <= '0;
      s1_exp_q    <= '0;
      s1_sticky_q <= 1'b0;
      s1_lzc_q    <= '0;
    end else if (in_fire) begin
      s1_carry_q  <= in_carry;
      s1_mant_q   <= in_mant;
      s1_exp_q    <= in_exp;
      s1_sticky_q <= in_sticky;
      s1_lzc_q    <= lzc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: shift and exponent adjust
  // ---------------------------------------------------------------------------
  logic [XW-1:0] exp_x;
  logic [XW-1:0] lzc_x;
  logic [XW-1:0] exp_inc;
  logic [XW-1:0] exp_max;
  logic [SW-1:0] unf_shift;

  assign exp_x   = XW'(s1_exp_q);
  assign lzc_x   = XW'(s1_lzc_q);
  assign exp_inc = exp_x + XW'(1);
  assign exp_max = XW'((2 ** EW) - 1);

  // Denormal shift stops one short of the exponent so the result lands on the
  // denormal encoding (exponent 0) without shifting past the floor.
  always_comb begin
    unf_shift = '0;
    if (s1_exp_q != '0) unf_shift = SW'(exp_x - XW'(1));
  end

  logic [MW-1:0] mant_d;
  logic [EW-1:0] exp_d;
  logic [SW-1:0] shift_d;
  logic          rshift_d;
  logic          sticky_d;
  logic          zero_d;
  logic          ovf_d;
  logic          unf_d;

  // Case selection in priority order: carry, zero, already normal, left shift, denormal.
  always_comb begin
    mant_d   = s1_mant_q;
    exp_d    = s1_exp_q;
    shift_d  = '0;
    rshift_d = 1'b0;
    sticky_d = s1_sticky_q;
    zero_d   = 1'b0;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (s1_carry_q) begin
      // Carry out: one-bit right shift; the dropped LSB folds into sticky.
      rshift_d = 1'b1;
      sticky_d = s1_sticky_q | s1_mant_q[0];
      if (exp_inc >= exp_max) begin
        ovf_d  = 1'b1;
        exp_d  = '1;
        mant_d = '0;
      end else begin
        mant_d = {1'b1, s1_mant_q[MW-1:1]};
        exp_d  = EW'(exp_inc);
      end
    end else if (s1_mant_q == '0) begin
      zero_d = 1'b1;
      mant_d = '0;
      exp_d  = '0;
    end else if (s1_mant_q[MW-1]) begin
      // Already normalised: pass through unchanged.
      mant_d = s1_mant_q;
    end else if (lzc_x < exp_x) begin
      mant_d  = s1_mant_q << s1_lzc_q;
      exp_d   = EW'(exp_x - lzc_x);
      shift_d = s1_lzc_q;
    end else begin
      unf_d   = 1'b1;
      exp_d   = '0;
      shift_d = unf_shift;
      mant_d  = s1_mant_q << unf_shift;
    end
  end

  logic [MW-1:0] mant_q;
  logic [EW-1:0] exp_q;
  logic [SW-1:0] shift_q;
  logic          rshift_q;
  logic          sticky_q;
  logic          zero_q;
  logic          ovf_q;
  logic          unf_q;

  // Output registers load when stage 1 hands over a beat; otherwise they hold,
  // which keeps the result stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mant_q   <= '0;
      exp_q    <= '0;
      shift_q  <= '0;
      rshift_q <= 1'b0;
      sticky_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (s2_fire) begin
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      shift_q  <= shift_d;
      rshift_q <= rshift_d;
      sticky_q <= sticky_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign out_valid  = s2_v_q;
  assign out_mant   = mant_q;
  assign out_exp    = exp_q;
  assign out_shift  = shift_q;
  assign out_rshift = rshift_q;
  assign out_sticky = sticky_q;
  assign out_zero   = zero_q;
  assign out_ovf    = ovf_q;
  assign out_unf    = unf_q;

  // Exception flags never overlap and the applied shift never exceeds MW-1.
  a_flags_excl: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> $onehot0({out_zero, out_ovf, out_unf}));
  a_shift_max: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> (out_shift <= SW'(MW - 1)));

endmodule

// File: tb/tb_norm_pipe.sv
// Directed bench for norm_pipe (MW=24, EW=8): single-beat cases, backpressure, reset flush.
// Inputs driven #1 after the rising edge; outputs sampled on the falling edge.
// All expected values are hand-computed constants in the stimulus below.
module tb_norm_pipe;

  localparam int MW = 24;
  localparam int EW = 8;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_carry;
  logic [MW-1:0] in_mant;
  logic [EW-1:0] in_exp;
  logic          in_sticky;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic [SW-1:0] out_shift;
  logic          out_rshift;
  logic          out_sticky;
  logic          out_zero;
  logic          out_ovf;
  logic          out_unf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  norm_pipe #(.MW(MW), .EW(EW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_carry   (in_carry),
    .in_mant    (in_mant),
    .in_exp     (in_exp),
    .in_sticky  (in_sticky),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mant   (out_mant),
    .out_exp    (out_exp),
    .out_shift  (out_shift),
    .out_rshift (out_rshift),
    .out_sticky (out_sticky),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One isolated beat with out_ready high; checks 2-cycle latency and every field.
  task automatic run_beat(input string tag,
                          input logic c, input logic [MW-1:0] m, input logic [EW-1:0] e,
                          input logic s,
                          input logic [MW-1:0] xm, input logic [EW-1:0] xe,
                          input logic [SW-1:0] xsh, input logic xrs, input logic xst,
                          input logic xz, input logic xo, input logic xu);
    @(posedge clk); #1;
    in_carry = c; in_mant = m; in_exp = e; in_sticky = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid"},  64'(out_valid),  64'd1);
    chk({tag, "_mant"},   64'(out_mant),   64'(xm));
    chk({tag, "_exp"},    64'(out_exp),    64'(xe));
    chk({tag, "_shift"},  64'(out_shift),  64'(xsh));
    chk({tag, "_rshift"}, 64'(out_rshift), 64'(xrs));
    chk({tag, "_sticky"}, 64'(out_sticky), 64'(xst));
    chk({tag, "_zero"},   64'(out_zero),   64'(xz));
    chk({tag, "_ovf"},    64'(out_ovf),    64'(xo));
    chk({tag, "_unf"},    64'(out_unf),    64'(xu));
  endtask

  // Backpressure beats and their hand-computed results.
  logic          bp_c  [4];
  logic [MW-1:0] bp_m  [4];
  logic [EW-1:0] bp_e  [4];
  logic [MW-1:0] bp_xm [4];
  logic [EW-1:0] bp_xe [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_carry = 1'b0; in_mant = '0; in_exp = '0;
    in_sticky = 1'b0; out_ready = 1'b1;

    bp_c[0] = 1'b0; bp_m[0] = 24'h800000; bp_e[0] = 8'd20; bp_xm[0] = 24'h800000; bp_xe[0] = 8'd20;
    bp_c[1] = 1'b0; bp_m[1] = 24'h400001; bp_e[1] = 8'd20; bp_xm[1] = 24'h800002; bp_xe[1] = 8'd19;
    bp_c[2] = 1'b0; bp_m[2] = 24'h00FFFF; bp_e[2] = 8'd30; bp_xm[2] = 24'hFFFF00; bp_xe[2] = 8'd22;
    bp_c[3] = 1'b1; bp_m[3] = 24'h000002; bp_e[3] = 8'd40; bp_xm[3] = 24'h800001; bp_xe[3] = 8'd41;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_mant",  64'(out_mant),  64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_exp",   64'(out_exp),   64'd0);
    chk("rst_out_flags", 64'({out_zero, out_ovf, out_unf, out_rshift, out_sticky}), 64'd0);

    //        tag           c     mant          exp     st    xmant         xexp    xsh     rs    st    z     o     u
    run_beat("carry",      1'b1, 24'h800001, 8'd10,  1'b0, 24'hC00000, 8'd11,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_beat("lshift12",   1'b0, 24'h000F00, 8'd100, 1'b0, 24'hF00000, 8'd88,  5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_beat("denorm",     1'b0, 24'h000001, 8'd5,   1'b0, 24'h000010, 8'd0,   5'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_beat("ovf",        1'b1, 24'h123456, 8'd254, 1'b0, 24'h000000, 8'd255, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_beat("zero",       1'b0, 24'h000000, 8'd77,  1'b1, 24'h000000, 8'd0,   5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_beat("pass",       1'b0, 24'hA5A5A5, 8'd200, 1'b1, 24'hA5A5A5, 8'd200, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_beat("denorm_e0",  1'b0, 24'h000100, 8'd0,   1'b0, 24'h000100, 8'd0,   5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_beat("lzc_eq_exp", 1'b0, 24'h001000, 8'd11,  1'b0, 24'h400000, 8'd0,   5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_beat("lzc_lt_exp", 1'b0, 24'h001000, 8'd12,  1'b0, 24'h800000, 8'd1,   5'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Backpressure: 4 back-to-back beats, consumer stalls for 3 cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin : producer
        logic acc;
        int   guard;
        for (int k = 0; k < 4; k++) begin
          in_carry = bp_c[k]; in_mant = bp_m[k]; in_exp = bp_e[k]; in_sticky = 1'b0;
          in_valid = 1'b1;
          acc = 1'b0;
          guard = 0;
          while (!acc && guard < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
          end
          chk("bp_accept", 64'(acc), 64'd1);
        end
        in_valid = 1'b0;
      end
      begin : consumer
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 40) begin
          @(posedge clk); #2;
          out_ready = (cyc >= 3);
          @(negedge clk);
          if (cyc == 1) begin
            chk("bp_in_ready_low", 64'(in_ready),  64'd0);
            chk("bp_held_valid",   64'(out_valid), 64'd1);
          end
          if (cyc == 2) begin
            chk("bp_stall_valid", 64'(out_valid), 64'd1);
            chk("bp_stall_mant",  64'(out_mant),  64'(bp_xm[0]));
            chk("bp_stall_rdy",   64'(in_ready),  64'd0);
          end
          if (out_valid && out_ready) begin
            chk("bp_mant", 64'(out_mant), 64'(bp_xm[got]));
            chk("bp_exp",  64'(out_exp),  64'(bp_xe[got]));
            got++;
          end
          cyc++;
        end
        chk("bp_count", 64'(got), 64'd4);
      end
    join
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Reset with both stages full
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_carry = 1'b0; in_mant = 24'h900000; in_exp = 8'd50; in_sticky = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_mant = 24'h000003; in_exp = 8'd60;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_in_ready",  64'(in_ready),  64'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_mant",  64'(out_mant),  64'd0);
    chk("flush_in_ready",  64'(in_ready),  64'd1);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    run_beat("post_rst",   1'b0, 24'h0000F0, 8'd30,  1'b0, 24'hF00000, 8'd14,  5'd16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
